sdt_mem_responder: RTL and testbench

Synthesizable SDT memory-side responder: the slave end of the SDT interface that the memory arbiter drives on its `m_*` port. It accepts one read or write at a time and stores data in an internal array. It returns `m_ack`, with read data, after a fixed, parameterized latency. It serves as the memory behind the arbiter in the block-level subsystem and as a reusable responder in benches. It flags illegal requests instead of hanging the requester.

---
 rtl/sdt_mem_responder.sv | 135 +++++++++++++
 tb/tb_sdt_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdt_mem_responder.sv
// Memory-side SDT responder: serves one read or write at a time from an internal
// array and acknowledges after a fixed LATENCY, flagging illegal requests with m_err.
module sdt_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_rd,
    input  logic                  m_wr,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wr_data,
    output logic [DATA_WIDTH-1:0] m_rd_data,
    output logic                  m_ack,
    output logic                  m_err,
    output logic                  busy
);

    localparam int                CNT_W     = $clog2(LATENCY + 1);
    localparam int                IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    op_wr_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ack_q;
    logic                    err_out_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   mem_q [0:MEM_DEPTH-1];

    logic                    req_d;
    logic                    illegal_d;
    logic [IDX_W-1:0]        idx_d;
    logic [DATA_WIDTH-1:0]   rd_word_d;

    // Request decode for the IDLE sample and array read port for the latched address.
    always_comb begin
        req_d     = m_rd | m_wr;
        illegal_d = 1'b0;
        if (m_rd && m_wr) begin
            illegal_d = 1'b1;
        end else if ({1'b0, m_addr} >= DEPTH_LIM) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = 1'b0;
        end
        idx_d     = addr_q[IDX_W-1:0];
        rd_word_d = mem_q[idx_d];
    end

    // Transaction FSM; ack, err, busy and read data are all registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            ack_q     <= 1'b0;
            err_out_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q     <= 1'b0;
                    err_out_q <= 1'b0;
                    if (req_d) begin
                        op_wr_q <= m_wr;
                        err_q   <= illegal_d;
                        addr_q  <= m_addr;
                        wdata_q <= m_wr_data;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Leaving WAIT at count zero puts the ack exactly LATENCY edges after the sample.
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_q   <= S_ACK;
                        ack_q     <= 1'b1;
                        err_out_q <= err_q;
                        if (err_q) begin
                            rd_data_q <= {DATA_WIDTH{1'b0}};
                        end else if (!op_wr_q) begin
                            rd_data_q <= rd_word_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    ack_q     <= 1'b0;
                    err_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    ack_q     <= 1'b0;
                    err_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Array write at the end of a legal write's ack cycle; contents are never reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_ACK) && op_wr_q && !err_q) begin
            mem_q[idx_d] <= wdata_q;
        end
    end

    assign m_ack     = ack_q;
    assign m_err     = err_out_q;
    assign busy      = busy_q;
    assign m_rd_data = rd_data_q;

endmodule

// File: tb/tb_sdt_mem_responder.sv
// Scoreboard bench for sdt_mem_responder: two instances (LATENCY=2/full depth and
// LATENCY=1/depth 16) checked against an array-based reference model.
module tb_sdt_mem_responder;

    typedef struct {
        int         due;
        bit         err;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rd_s    [2];
    logic       wr_s    [2];
    logic [7:0] addr_s  [2];
    logic [7:0] wdata_s [2];
    logic       ack0, ack1, err0, err1, busy0, busy1;
    logic [7:0] rdata0, rdata1;
    logic       ack_s   [2];
    logic       err_s   [2];
    logic       busy_s  [2];
    logic [7:0] rdata_s [2];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         depth   [2] = '{256, 16};
    int         lat     [2] = '{2, 1};
    logic [7:0] mdl     [2][256];
    bit         known   [2][256];
    logic [7:0] last_rd [2];
    bit         last_ok [2];
    exp_t       q0[$];
    exp_t       q1[$];

    sdt_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .m_rd(rd_s[0]), .m_wr(wr_s[0]), .m_addr(addr_s[0]),
        .m_wr_data(wdata_s[0]), .m_rd_data(rdata0), .m_ack(ack0), .m_err(err0), .busy(busy0)
    );

    sdt_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .m_rd(rd_s[1]), .m_wr(wr_s[1]), .m_addr(addr_s[1]),
        .m_wr_data(wdata_s[1]), .m_rd_data(rdata1), .m_ack(ack1), .m_err(err1), .busy(busy1)
    );

    assign ack_s[0]   = ack0;
    assign ack_s[1]   = ack1;
    assign err_s[0]   = err0;
    assign err_s[1]   = err1;
    assign busy_s[0]  = busy0;
    assign busy_s[1]  = busy1;
    assign rdata_s[0] = rdata0;
    assign rdata_s[1] = rdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail_msg(input string name, input int got, input int want);
        n_fail++;
        $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        n_tests++;
        if (busy_s[d] !== have) fail_msg($sformatf("busy[%0d]", d), int'(busy_s[d]), int'(have));
        if (err_s[d] === 1'b1 && ack_s[d] !== 1'b1) begin
            n_tests++;
            fail_msg($sformatf("err_without_ack[%0d]", d), 1, 0);
        end
        if (ack_s[d] === 1'b1) begin
            if (!have) begin
                n_tests++;
                fail_msg($sformatf("unexpected_ack[%0d]", d), 1, 0);
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                n_tests++;
                if (cyc != e.due) fail_msg($sformatf("ack_cycle[%0d]", d), cyc, e.due);
                n_tests++;
                if (err_s[d] !== e.err) fail_msg($sformatf("m_err[%0d]", d), int'(err_s[d]), int'(e.err));
                if (e.chk) begin
                    n_tests++;
                    if (rdata_s[d] !== e.data) fail_msg($sformatf("rd_data[%0d]", d), int'(rdata_s[d]), int'(e.data));
                end
            end
        end else if (have && cyc > e.due) begin
            n_tests++;
            fail_msg($sformatf("missing_ack[%0d]", d), 0, 1);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    // Monitor: compares every ack against the oldest expectation for that port.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic start_req(input int d, input bit r, input bit w, input logic [7:0] a,
                             input logic [7:0] wd, input bit abort);
        exp_t e;
        bit   ill;
        rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk); #1;
        ill   = (r && w) || (int'(a) >= depth[d]);
        e.due = abort ? cyc + 1000 : cyc + lat[d];
        e.err = ill;
        if (ill) begin
            e.chk = 1'b1; e.data = 8'h00;
            last_rd[d] = 8'h00; last_ok[d] = 1'b1;
        end else if (r) begin
            e.chk = known[d][a]; e.data = mdl[d][a];
            last_rd[d] = mdl[d][a]; last_ok[d] = known[d][a];
        end else begin
            e.chk = last_ok[d]; e.data = last_rd[d];
            if (!abort) begin
                mdl[d][a] = wd; known[d][a] = 1'b1;
            end
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic do_req(input int d, input bit r, input bit w, input logic [7:0] a,
                          input logic [7:0] wd, input bit drop);
        int waited;
        bit got;
        start_req(d, r, w, a, wd, 1'b0);
        if (drop) begin
            @(negedge clk);
            rd_s[d] = 1'b0; wr_s[d] = 1'b0;
            addr_s[d] = 8'($urandom); wdata_s[d] = 8'($urandom);
        end
        got = 1'b0; waited = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (ack_s[d] === 1'b1) got = 1'b1; else waited++;
        end
        if (!got) begin
            n_tests++;
            fail_msg($sformatf("ack_timeout[%0d]", d), 0, 1);
        end
        rd_s[d] = 1'b0; wr_s[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({ack_s[d], err_s[d], busy_s[d]} !== 3'b000 || rdata_s[d] !== 8'h00)
                fail_msg($sformatf("reset_outputs[%0d]", d),
                         int'({ack_s[d], err_s[d], busy_s[d], rdata_s[d]}), 0);
        end
    endtask

    task automatic abort_write(input int d, input logic [7:0] a, input logic [7:0] wd);
        start_req(d, 1'b0, 1'b1, a, wd, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        rd_s[d] = 1'b0; wr_s[d] = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = 8'h00; last_ok[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int         d, op;
        logic [7:0] a;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = 8'h00; wdata_s[k] = 8'h00;
            last_rd[k] = 8'h00; last_ok[k] = 1'b1;
            for (int j = 0; j < 256; j++) begin
                known[k][j] = 1'b0; mdl[k][j] = 8'h00;
            end
        end
        #3 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rd_s[k] = 1'($urandom); wr_s[k] = 1'($urandom);
                addr_s[k] = 8'($urandom); wdata_s[k] = 8'($urandom);
            end
            #1 check_reset_outputs();
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);

        do_req(0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
        do_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        do_req(0, 1'b0, 1'b1, 8'h01, 8'h11, 1'b0);
        do_req(0, 1'b0, 1'b1, 8'h02, 8'h22, 1'b0);
        do_req(0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        do_req(0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        @(negedge clk);
        do_req(0, 1'b0, 1'b1, 8'h05, 8'h77, 1'b0);
        do_req(0, 1'b1, 1'b1, 8'h10, 8'hFF, 1'b0);
        do_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        do_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1);

        do_req(1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0);
        do_req(1, 1'b0, 1'b1, 8'h20, 8'hEE, 1'b0);
        do_req(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        do_req(1, 1'b0, 1'b1, 8'h0F, 8'h9C, 1'b0);
        do_req(1, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b1);
        do_req(1, 1'b0, 1'b1, 8'h10, 8'h01, 1'b1);

        do_req(0, 1'b0, 1'b1, 8'h03, 8'h33, 1'b0);
        abort_write(0, 8'h03, 8'h5A);
        do_req(0, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
        do_req(1, 1'b0, 1'b1, 8'h03, 8'h33, 1'b0);
        abort_write(1, 8'h03, 8'h5A);
        do_req(1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0);

        for (int i = 0; i < 200; i++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 9);
            a  = (d == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 40));
            if (op == 0)      do_req(d, 1'b1, 1'b1, a, 8'($urandom), 1'($urandom));
            else if (op < 5)  do_req(d, 1'b1, 1'b0, a, 8'($urandom), 1'($urandom));
            else              do_req(d, 1'b0, 1'b1, a, 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        n_tests++;
        if (q0.size() + q1.size() != 0) fail_msg("pending_expectations", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
